// File: rtl/fb_stream_reader.sv
// rtl/fb_stream_reader.sv - frame-buffer scan-out: RAM read sequencer to valid/ready pixel stream
module fb_stream_reader #(
    parameter int WIDTH  = 8,
    parameter int LEN    = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              loop_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [WIDTH-1:0]  ram_din_o,
    input  logic [WIDTH-1:0]  ram_dout_i,
    output logic [WIDTH-1:0]  pix_data_o,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic              pix_last_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic              at_last;

    assign at_last = (idx_q == LAST_IDX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // The RAM address runs one word ahead on a transfer, so the next word is
    // already on ram_dout when it becomes visible; on a stall the same word is
    // re-read, which keeps pix_data stable without a skid register.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        ram_addr_o  = idx_q;
        pix_valid_o = 1'b0;
        pix_last_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_PRIME;
                    idx_d   = '0;
                end
            end
            S_PRIME: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                pix_valid_o = 1'b1;
                pix_last_o  = at_last;
                if (pix_ready_i) begin
                    if (!at_last) begin
                        idx_d = idx_q + ADDR_W'(1);
                    end else begin
                        idx_d = '0;
                        if (!loop_i) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    ram_addr_o = idx_d;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign pix_data_o = ram_dout_i;
    assign ram_we_o   = 1'b0;
    assign ram_din_o  = '0;

endmodule

// File: tb/tb_fb_stream_reader.sv
// tb/tb_fb_stream_reader.sv - directed bench for fb_stream_reader (LEN=4096 and LEN=6 builds)
module tb_fb_stream_reader;

    localparam int LEN = 4096;
    localparam int LEN6 = 6;

    logic        clk = 1'b0;
    logic        rst, start, loop, ready;
    logic        busy, done, we, valid, last;
    logic [11:0] addr;
    logic [7:0]  din, dout, data;
    logic [7:0]  mem [LEN];

    logic        s_start, s_loop, s_ready;
    logic        s_busy, s_done, s_we, s_valid, s_last;
    logic [2:0]  s_addr;
    logic [7:0]  s_din, s_dout, s_data;
    logic [7:0]  mem6 [LEN6];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) dout <= mem[addr];
    always @(posedge clk) s_dout <= mem6[s_addr];

    fb_stream_reader #(.WIDTH(8), .LEN(LEN), .ADDR_W(12)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .loop_i(loop),
        .busy_o(busy), .done_o(done), .ram_addr_o(addr), .ram_we_o(we),
        .ram_din_o(din), .ram_dout_i(dout), .pix_data_o(data),
        .pix_valid_o(valid), .pix_ready_i(ready), .pix_last_o(last)
    );

    fb_stream_reader #(.WIDTH(8), .LEN(LEN6), .ADDR_W(3)) dut6 (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .loop_i(s_loop),
        .busy_o(s_busy), .done_o(s_done), .ram_addr_o(s_addr), .ram_we_o(s_we),
        .ram_din_o(s_din), .ram_dout_i(s_dout), .pix_data_o(s_data),
        .pix_valid_o(s_valid), .pix_ready_i(s_ready), .pix_last_o(s_last)
    );

    // Runs the big instance until nfires transfers or budget cycles; returns
    // statistics only. Pattern 0: ready always 1; pattern 1: ready 1,0,0,1 repeating.
    task automatic stream(input int exp0, input int nfires, input int pattern, input int budget,
                          output int fires, output int data_err, output int last_err,
                          output int stall_err, output int gaps, output int dones, output int cyc);
        int exp, ph;
        logic stalled;
        logic [7:0] pd;
        exp = exp0; ph = 0; stalled = 1'b0; pd = '0;
        fires = 0; data_err = 0; last_err = 0; stall_err = 0; gaps = 0; dones = 0; cyc = 0;
        while (fires < nfires && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (done) dones++;
            if (!valid) gaps++;
            else begin
                if (data !== 8'(exp)) data_err++;
                if (last !== (exp == LEN - 1)) last_err++;
                if (stalled && data !== pd) stall_err++;
            end
            ready = (pattern == 0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
            ph++;
            stalled = valid && !ready;
            if (valid && ready) begin
                fires++;
                exp = (exp + 1) % LEN;
            end
            pd = data;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
        checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", last); end
        checks++; if (addr !== 12'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr); end
        checks++; if (we !== 1'b0 || din !== 8'd0) begin errors++; $display("FAIL ram_write_tie got we=%0b din=%0d want 0 0", we, din); end
    endtask

    task automatic test_basic();
        int f, de, le, se, g, d, c;
        loop = 1'b0;
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prime_busy got %0b want 1", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL prime_valid got %0b want 0", valid); end
        stream(0, LEN, 0, LEN + 100, f, de, le, se, g, d, c);
        checks++; if (f !== LEN) begin errors++; $display("FAIL basic_fires got %0d want %0d", f, LEN); end
        checks++; if (c !== LEN) begin errors++; $display("FAIL basic_cycles got %0d want %0d", c, LEN); end
        checks++; if (de !== 0) begin errors++; $display("FAIL basic_data_errs got %0d want 0", de); end
        checks++; if (le !== 0) begin errors++; $display("FAIL basic_last_errs got %0d want 0", le); end
        checks++; if (g !== 0) begin errors++; $display("FAIL basic_gaps got %0d want 0", g); end
        checks++; if (d !== 0) begin errors++; $display("FAIL basic_early_done got %0d want 0", d); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %0b want 1", done); end
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL basic_end busy=%0b valid=%0b want 0 0", busy, valid); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %0b want 0", done); end
    endtask

    task automatic test_stall();
        int f, de, le, se, g, d, c;
        loop = 1'b0;
        pulse_start();
        stream(0, LEN, 1, 3 * LEN, f, de, le, se, g, d, c);
        checks++; if (f !== LEN) begin errors++; $display("FAIL stall_fires got %0d want %0d", f, LEN); end
        checks++; if (de !== 0) begin errors++; $display("FAIL stall_data_errs got %0d want 0", de); end
        checks++; if (se !== 0) begin errors++; $display("FAIL stall_unstable got %0d want 0", se); end
        checks++; if (g !== 0 || le !== 0) begin errors++; $display("FAIL stall_gaps_last got gaps=%0d last_errs=%0d want 0 0", g, le); end
        ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %0b want 1", done); end
    endtask

    task automatic test_loop();
        int f, de, le, se, g, d, c;
        int f2, de2, le2, se2, g2, d2, c2;
        loop = 1'b1;
        pulse_start();
        stream(0, LEN, 0, LEN + 100, f, de, le, se, g, d, c);
        stream(0, 1, 0, 10, f2, de2, le2, se2, g2, d2, c2);
        checks++; if (g2 !== 0 || de2 !== 0) begin errors++; $display("FAIL loop_wrap got gaps=%0d data_errs=%0d want 0 0", g2, de2); end
        checks++; if (d !== 0 || d2 !== 0) begin errors++; $display("FAIL loop_no_done got %0d want 0", d + d2); end
        loop = 1'b0;
        stream(1, LEN - 1, 0, LEN + 100, f2, de2, le2, se2, g2, d2, c2);
        checks++; if (f + 1 + f2 !== 2 * LEN) begin errors++; $display("FAIL loop_fires got %0d want %0d", f + 1 + f2, 2 * LEN); end
        checks++; if (de + de2 + le + le2 + g + g2 + d2 !== 0) begin errors++; $display("FAIL loop_stream_errs got %0d want 0", de + de2 + le + le2 + g + g2 + d2); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL loop_done got done=%0b busy=%0b want 1 0", done, busy); end
    endtask

    task automatic test_reset_mid();
        int f, de, le, se, g, d, c, nd;
        loop = 1'b0;
        pulse_start();
        stream(0, 100, 0, 200, f, de, le, se, g, d, c);
        @(posedge clk); #1;
        checks++; if (valid !== 1'b1 || data !== 8'd100) begin errors++; $display("FAIL rst_pre got valid=%0b data=%0d want 1 100", valid, data); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_abort got valid=%0b busy=%0b want 0 0", valid, busy); end
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) nd++;
            @(posedge clk); #1;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", nd); end
        pulse_start();
        stream(0, LEN, 0, LEN + 100, f, de, le, se, g, d, c);
        checks++; if (de !== 0 || f !== LEN) begin errors++; $display("FAIL rst_rescan got data_errs=%0d fires=%0d want 0 %0d", de, f, LEN); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_rescan_done got %0b want 1", done); end
    endtask

    task automatic test_busy_start();
        int f, de, le, se, g, d, c;
        loop = 1'b0;
        pulse_start();
        stream(0, 10, 0, 50, f, de, le, se, g, d, c);
        start = 1'b1;
        stream(10, LEN - 10, 0, LEN + 100, f, de, le, se, g, d, c);
        checks++; if (f !== LEN - 10 || c !== LEN - 10) begin errors++; $display("FAIL busy_start_count got fires=%0d cycles=%0d want %0d", f, c, LEN - 10); end
        checks++; if (de !== 0 || g !== 0 || d !== 0) begin errors++; $display("FAIL busy_start_stream got data=%0d gaps=%0d done=%0d want 0 0 0", de, g, d); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_start_done got %0b want 1", done); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_restart got busy=%0b want 0", busy); end
    endtask

    task automatic test_len6();
        int fires, bad_data, bad_last, bad_addr, gaps, dones, k;
        fires = 0; bad_data = 0; bad_last = 0; bad_addr = 0; gaps = 0; dones = 0;
        s_loop = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b1;
        s_ready = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int c = 0; c < 60 && fires < 18; c++) begin
            @(posedge clk); #1;
            if (s_done) dones++;
            if (!s_valid) gaps++;
            else begin
                if (s_data !== 8'hA0 + 8'(fires % LEN6)) bad_data++;
                if (s_last !== (fires % LEN6 == LEN6 - 1)) bad_last++;
            end
            s_ready = (c % 3 != 1);
            s_loop = (fires < 12);
            if (s_addr > 3'd5) bad_addr++;
            if (s_valid && s_ready) fires++;
        end
        k = fires;
        checks++; if (k !== 18) begin errors++; $display("FAIL len6_fires got %0d want 18", k); end
        checks++; if (bad_data !== 0 || bad_last !== 0) begin errors++; $display("FAIL len6_seq got data_errs=%0d last_errs=%0d want 0 0", bad_data, bad_last); end
        checks++; if (bad_addr !== 0) begin errors++; $display("FAIL len6_addr_range got %0d want 0", bad_addr); end
        checks++; if (gaps !== 0 || dones !== 0) begin errors++; $display("FAIL len6_gaps_done got gaps=%0d dones=%0d want 0 0", gaps, dones); end
        @(posedge clk); #1;
        checks++; if (s_done !== 1'b1 || s_busy !== 1'b0) begin errors++; $display("FAIL len6_done got done=%0b busy=%0b want 1 0", s_done, s_busy); end
    endtask

    initial begin
        for (int i = 0; i < LEN; i++) mem[i] = 8'(i);
        for (int i = 0; i < LEN6; i++) mem6[i] = 8'hA0 + 8'(i);
        rst = 1'b1; start = 1'b0; loop = 1'b0; ready = 1'b0;
        s_start = 1'b0; s_loop = 1'b0; s_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_basic();
        test_stall();
        test_loop();
        test_reset_mid();
        test_busy_start();
        test_len6();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
